// File: rtl/sync_fifo_rd_pkg.sv
// Shared constants, FSM state encoding and output word payload for the
// FIFO-read byte packer.
package sync_fifo_rd_pkg;

   localparam int unsigned OUT_BYTES = 4;
   localparam int unsigned BYTE_W    = 8;
   localparam int unsigned WORD_W    = OUT_BYTES * BYTE_W;
   localparam int unsigned KEEP_W    = OUT_BYTES;
   localparam int unsigned CNT_W     = $clog2(OUT_BYTES + 1);
   localparam int unsigned LANE_W    = $clog2(OUT_BYTES);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      EMIT  = 2'd2
   } state_t;

   typedef struct packed {
      logic [WORD_W-1:0] data;
      logic [KEEP_W-1:0] keep;
      logic              last;
   } out_word_t;

   // Contiguous lane mask covering the lowest cnt lanes.
   function automatic logic [KEEP_W-1:0] keep_mask(input logic [CNT_W-1:0] cnt);
      logic [KEEP_W-1:0] m;
      m = '0;
      for (int unsigned i = 0; i < KEEP_W; i++) begin
         m[i] = (CNT_W'(i) < cnt);
      end
      return m;
   endfunction

endpackage

// File: rtl/byte_pack_4to32.sv
// Lane register and fill counter: collects bytes into a 32-bit word and
// presents the word (including a byte arriving this cycle) for hand-off.
module byte_pack_4to32
   import sync_fifo_rd_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              capture,
   input  logic [BYTE_W-1:0] byte_in,
   input  logic              take,
   output logic [CNT_W-1:0]  pack_cnt,
   output logic [WORD_W-1:0] word_c,
   output logic [KEEP_W-1:0] keep_c,
   output logic              full_c
);

   logic [OUT_BYTES-1:0][BYTE_W-1:0] lanes;
   logic [OUT_BYTES-1:0][BYTE_W-1:0] merged;
   logic [CNT_W-1:0]                 cnt_c;
   logic [LANE_W-1:0]                idx;

   assign idx   = pack_cnt[LANE_W-1:0];
   assign cnt_c = pack_cnt + CNT_W'(capture);

   // Forward the arriving byte so a completed word can leave in the same cycle.
   always_comb begin
      merged = lanes;
      if (capture) begin
         merged[idx] = byte_in;
      end
   end

   assign word_c = merged;
   assign keep_c = keep_mask(cnt_c);
   assign full_c = (cnt_c == CNT_W'(OUT_BYTES));

   // Lanes are cleared on hand-off so unused lanes of a partial word read as zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lanes    <= '0;
         pack_cnt <= '0;
      end else if (take) begin
         lanes    <= '0;
         pack_cnt <= '0;
      end else if (capture) begin
         lanes[idx] <= byte_in;
         pack_cnt   <= cnt_c;
      end
   end

endmodule

// File: rtl/sync_fifo_rd_pack32.sv
// Reads bytes from a synchronous FIFO and packs them into 32-bit words with
// a one-entry output slot; flush emits any partial word marked with m_last.
module sync_fifo_rd_pack32 #(
   parameter int unsigned OUT_BYTES = 4,
   parameter int unsigned BYTE_W    = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        enable,
   input  logic                        flush,
   output logic                        rd_en,
   input  logic [BYTE_W-1:0]           rd_data,
   input  logic                        rd_empty,
   output logic                        m_valid,
   input  logic                        m_ready,
   output logic [OUT_BYTES*BYTE_W-1:0] m_data,
   output logic [OUT_BYTES-1:0]        m_keep,
   output logic                        m_last,
   output logic                        flush_done
);
   import sync_fifo_rd_pkg::*;

   state_t            state;
   state_t            next_state;
   logic              inflight;
   logic [CNT_W-1:0]  pack_cnt;
   logic [WORD_W-1:0] word_c;
   logic [KEEP_W-1:0] keep_c;
   logic              full_c;
   logic              slot_free_c;
   logic              load_full_c;
   logic              load_part_c;
   logic              take_c;
   out_word_t         slot;

   assign slot_free_c = !m_valid || m_ready;
   assign load_full_c = full_c && slot_free_c;
   assign load_part_c = (state == EMIT) && (pack_cnt != '0) && slot_free_c;
   assign take_c      = load_full_c || load_part_c;

   // At most one byte in flight; counting it keeps the lane register from overfilling.
   assign rd_en = rst_n && !rd_empty && enable && (state == RUN) &&
                  ((pack_cnt + CNT_W'(inflight)) < CNT_W'(OUT_BYTES));

   byte_pack_4to32 u_pack (
      .clk      (clk),
      .rst_n    (rst_n),
      .capture  (inflight),
      .byte_in  (rd_data),
      .take     (take_c),
      .pack_cnt (pack_cnt),
      .word_c   (word_c),
      .keep_c   (keep_c),
      .full_c   (full_c)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= RUN;
         inflight <= 1'b0;
      end else begin
         state    <= next_state;
         inflight <= rd_en;
      end
   end

   // DRAIN waits for the last read to land and any full pack to reach the slot.
   always_comb begin
      next_state = state;
      flush_done = 1'b0;
      case (state)
         RUN: begin
            if (flush) begin
               next_state = DRAIN;
            end
         end
         DRAIN: begin
            if (!inflight && (pack_cnt != CNT_W'(OUT_BYTES))) begin
               next_state = EMIT;
            end
         end
         EMIT: begin
            if ((pack_cnt == '0) || slot_free_c) begin
               next_state = RUN;
               flush_done = 1'b1;
            end
         end
         default: begin
            next_state = RUN;
         end
      endcase
   end

   // Output slot holds its contents until popped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid <= 1'b0;
         slot    <= '0;
      end else if (take_c) begin
         m_valid   <= 1'b1;
         slot.data <= word_c;
         slot.keep <= keep_c;
         slot.last <= load_part_c;
      end else if (m_ready) begin
         m_valid <= 1'b0;
      end
   end

   assign m_data = slot.data;
   assign m_keep = slot.keep;
   assign m_last = slot.last;

endmodule

// File: tb/tb_sync_fifo_rd_pack32.sv
// Directed bench for sync_fifo_rd_pack32 with a behavioural FIFO and output
// collector; ends with a long randomised ordering run.
module tb_sync_fifo_rd_pack32;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic        flush = 1'b0;
   logic        rd_en;
   logic [7:0]  rd_data = 8'h00;
   logic        rd_empty = 1'b1;
   logic        m_valid;
   logic        m_ready = 1'b0;
   logic [31:0] m_data;
   logic [3:0]  m_keep;
   logic        m_last;
   logic        flush_done;

   always #5 clk = ~clk;

   sync_fifo_rd_pack32 #(.OUT_BYTES(4), .BYTE_W(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .flush      (flush),
      .rd_en      (rd_en),
      .rd_data    (rd_data),
      .rd_empty   (rd_empty),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .m_keep     (m_keep),
      .m_last     (m_last),
      .flush_done (flush_done)
   );

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  keep;
      logic        last;
   } word_t;

   int unsigned vectors = 0;
   int unsigned errors = 0;
   logic [7:0]  fifo[$];
   logic [7:0]  expq[$];
   word_t       outq[$];
   int unsigned fd_cnt = 0;
   int unsigned rd_viol = 0;
   int unsigned stab_viol = 0;
   logic        hold_empty = 1'b0;
   logic        s_rd_en, s_mv, s_fd;
   word_t       s_word;
   word_t       prev_word = '0;
   logic        prev_stall = 1'b0;
   logic [31:0] rdp, mvp, fdp;
   word_t       w;
   logic [31:0] stall_data;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic upd();
      rd_empty = (fifo.size() == 0) || hold_empty;
   endtask

   task automatic push4(input logic [31:0] v);
      for (int k = 0; k < 4; k++) fifo.push_back(v[8*k +: 8]);
   endtask

   // One clock: sample on the falling edge, then model the FIFO after the rising edge.
   task automatic step();
      @(negedge clk);
      s_rd_en = rd_en;
      s_mv    = m_valid;
      s_fd    = flush_done;
      s_word  = {m_data, m_keep, m_last};
      if (rd_en && rd_empty) rd_viol++;
      if (prev_stall && (!s_mv || (s_word !== prev_word))) stab_viol++;
      prev_stall = m_valid && !m_ready;
      prev_word  = s_word;
      if (m_valid && m_ready) outq.push_back(s_word);
      if (flush_done) fd_cnt++;
      @(posedge clk);
      #1;
      if (s_rd_en && (fifo.size() > 0)) rd_data = fifo.pop_front();
      upd();
   endtask

   function automatic word_t first_out();
      return (outq.size() > 0) ? outq[0] : word_t'('0);
   endfunction

   initial begin
      int bad;
      int budget;

      // Reset values, with a non-empty FIFO offered so rd_en gating is visible.
      enable   = 1'b1;
      rd_empty = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("rst_rd_en", 32'(rd_en), 32'd0);
      chk("rst_m_valid", 32'(m_valid), 32'd0);
      chk("rst_m_data", m_data, 32'd0);
      chk("rst_m_keep", 32'(m_keep), 32'd0);
      chk("rst_m_last", 32'(m_last), 32'd0);
      chk("rst_flush_done", 32'(flush_done), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      upd();

      // Single word, latency and lane order.
      m_ready = 1'b1;
      push4(32'h44332211);
      upd();
      rdp = '0; mvp = '0; outq.delete();
      for (int c = 0; c < 10; c++) begin
         step();
         rdp[c] = s_rd_en;
         mvp[c] = s_mv;
      end
      w = first_out();
      chk("w1_rd_en_cycles", rdp, 32'h0000_000F);
      chk("w1_valid_cycles", mvp, 32'h0000_0020);
      chk("w1_count", 32'(outq.size()), 32'd1);
      chk("w1_data", w.data, 32'h44332211);
      chk("w1_keep", 32'(w.keep), 32'hF);
      chk("w1_last", 32'(w.last), 32'd0);

      // Back-pressure: second pack held, reads stall, each word exactly once.
      m_ready = 1'b0;
      push4(32'h04030201);
      push4(32'h08070605);
      upd();
      rdp = '0; mvp = '0; outq.delete(); stall_data = '0;
      for (int c = 0; c < 20; c++) begin
         if (c == 12) m_ready = 1'b1;
         step();
         rdp[c] = s_rd_en;
         mvp[c] = s_mv;
         if (c == 10) stall_data = s_word.data;
      end
      chk("bp_rd_en_cycles", rdp, 32'h0000_01EF);
      chk("bp_valid_cycles", mvp, 32'h0000_3FE0);
      chk("bp_stall_data", stall_data, 32'h04030201);
      chk("bp_count", 32'(outq.size()), 32'd2);
      w = first_out();
      chk("bp_word0", w.data, 32'h04030201);
      w = (outq.size() > 1) ? outq[1] : word_t'('0);
      chk("bp_word1", w.data, 32'h08070605);

      // Dropping enable stops new reads but the in-flight byte still lands.
      push4(32'hD4D3D2D1);
      upd();
      rdp = '0; mvp = '0; outq.delete();
      for (int c = 0; c < 15; c++) begin
         if (c == 1) enable = 1'b0;
         if (c == 5) enable = 1'b1;
         step();
         rdp[c] = s_rd_en;
         mvp[c] = s_mv;
      end
      w = first_out();
      chk("en_rd_en_cycles", rdp, 32'h0000_00E1);
      chk("en_valid_cycles", mvp, 32'h0000_0200);
      chk("en_data", w.data, 32'hD4D3D2D1);

      // Partial-word flush; the second flush cycle lands in DRAIN and is ignored.
      fifo.push_back(8'hAA);
      fifo.push_back(8'hBB);
      fifo.push_back(8'hCC);
      upd();
      rdp = '0; mvp = '0; fdp = '0; outq.delete();
      for (int c = 0; c < 12; c++) begin
         flush = (c == 2) || (c == 3);
         step();
         rdp[c] = s_rd_en;
         mvp[c] = s_mv;
         fdp[c] = s_fd;
      end
      flush = 1'b0;
      w = first_out();
      chk("fl_rd_en_cycles", rdp, 32'h0000_0007);
      chk("fl_done_cycles", fdp, 32'h0000_0020);
      chk("fl_valid_cycles", mvp, 32'h0000_0040);
      chk("fl_data", w.data, 32'h00CCBBAA);
      chk("fl_keep", 32'(w.keep), 32'h7);
      chk("fl_last", 32'(w.last), 32'd1);

      // Flush with nothing packed: no word, flush_done only.
      mvp = '0; fdp = '0; outq.delete();
      for (int c = 0; c < 8; c++) begin
         flush = (c == 0);
         step();
         mvp[c] = s_mv;
         fdp[c] = s_fd;
      end
      flush = 1'b0;
      chk("fe_done_cycles", fdp, 32'h0000_0004);
      chk("fe_valid_cycles", mvp, 32'd0);

      // Reset after two bytes packed; fresh bytes form a clean word.
      fifo.push_back(8'h5A);
      fifo.push_back(8'h6B);
      upd();
      for (int c = 0; c < 3; c++) step();
      rst_n = 1'b0;
      push4(32'hC4C3C2C1);
      upd();
      step();
      chk("mr_rd_en", 32'(s_rd_en), 32'd0);
      chk("mr_m_valid", 32'(s_mv), 32'd0);
      chk("mr_word", s_word.data, 32'd0);
      chk("mr_keep_last", {27'd0, s_word.keep, s_word.last}, 32'd0);
      chk("mr_flush_done", 32'(s_fd), 32'd0);
      rst_n = 1'b1;
      rdp = '0; mvp = '0; outq.delete(); fd_cnt = 0;
      for (int c = 0; c < 12; c++) begin
         step();
         rdp[c] = s_rd_en;
         mvp[c] = s_mv;
      end
      w = first_out();
      chk("mr_rd_en_cycles", rdp, 32'h0000_000F);
      chk("mr_valid_cycles", mvp, 32'h0000_0020);
      chk("mr_count", 32'(outq.size()), 32'd1);
      chk("mr_data", w.data, 32'hC4C3C2C1);
      chk("mr_keep", 32'(w.keep), 32'hF);
      chk("mr_no_flush_done", fd_cnt, 32'd0);

      // Random empty/ready over 10000 bytes: order preserved, no reads while empty.
      outq.delete(); fd_cnt = 0;
      for (int i = 0; i < 10000; i++) begin
         logic [7:0] b;
         b = 8'($urandom_range(0, 255));
         fifo.push_back(b);
         expq.push_back(b);
      end
      budget = 0;
      while ((outq.size() < 2500) && (budget < 60000)) begin
         hold_empty = ($urandom_range(0, 3) == 0);
         m_ready    = ($urandom_range(0, 3) != 0);
         upd();
         step();
         budget++;
      end
      hold_empty = 1'b0;
      m_ready    = 1'b1;
      upd();
      bad = 0;
      for (int i = 0; i < outq.size(); i++) begin
         if ((outq[i].keep !== 4'hF) || (outq[i].last !== 1'b0)) bad++;
         for (int k = 0; k < 4; k++) begin
            if (outq[i].data[8*k +: 8] !== expq[4*i + k]) bad++;
         end
      end
      chk("rnd_word_count", 32'(outq.size()), 32'd2500);
      chk("rnd_fifo_left", 32'(fifo.size()), 32'd0);
      chk("rnd_bad_bytes", 32'(bad), 32'd0);
      chk("rnd_no_flush_done", fd_cnt, 32'd0);
      chk("rd_en_while_empty", rd_viol, 32'd0);
      chk("stall_stability", stab_viol, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/sync_fifo_rd_pack32.md
SYNC_FIFO_RD_PACK32 -- requirements
Module: sync_fifo_rd_pack32

Interface
REQ-001 SHALL have parameter OUT_BYTES, default 4: bytes per output word; legal value 4 only.
REQ-002 SHALL have parameter BYTE_W, default 8: FIFO byte width; legal value 8 only.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clk  in  1  sole clock; all logic rising-edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 enable  in  1  permits new FIFO reads while high.
REQ-007 flush  in  1  one-cycle request to emit any partial word.
REQ-008 rd_en  out  1  FIFO read strobe.
REQ-009 rd_data  in  8  FIFO read data; valid the cycle after an accepted rd_en (no output register).
REQ-010 rd_empty  in  1  FIFO empty flag.
REQ-011 m_valid  out  1  output word valid.
REQ-012 m_ready  in  1  downstream accept.
REQ-013 m_data  out  32  packed word; byte 0 = first byte read, in m_data[7:0].
REQ-014 m_keep  out  4  byte-lane valid mask, contiguous from lane 0.
REQ-015 m_last  out  1  marks the word closing a flush.
REQ-016 flush_done  out  1  one-cycle pulse when a flush completes.

Function
REQ-017 rd_en SHALL equal !rd_empty && enable && state==RUN && (pack_cnt + inflight) < 4.
REQ-018 inflight (0..1) SHALL be set by rd_en and cleared on the next cycle, when rd_data is captured into lane pack_cnt.
REQ-019 When the 4th byte is captured and the output slot is empty or popped (m_valid && m_ready) that cycle, the word SHALL load into the slot with m_keep=4'b1111, m_last=0, pack_cnt=0.
REQ-020 If the slot is occupied and not popped, the full pack SHALL be held (pack_cnt=4) and move in the first cycle the slot frees.
REQ-021 m_data/m_keep/m_last SHALL stay stable while m_valid && !m_ready.
REQ-022 Latency: rd_en in cycle 0 on an empty block SHALL give m_valid in cycle 5 (4 reads in cycles 0-3, word registered end of cycle 4).
REQ-023 Sustained throughput with m_ready=1 and FIFO non-empty SHALL be 4 bytes per 5 cycles.
REQ-024 States: RUN, DRAIN, EMIT. RUN->DRAIN on flush; DRAIN->EMIT when inflight==0 and any full pack has moved to the slot; EMIT->RUN when the flush word loads into the slot, or immediately if pack_cnt==0.
REQ-025 In EMIT with pack_cnt>0, the partial word SHALL load when the slot frees: unused lanes 0, m_keep = (1<<pack_cnt)-1, m_last=1.
REQ-026 With pack_cnt==0 in EMIT, no word SHALL be produced; flush_done SHALL still pulse.
REQ-027 flush_done SHALL pulse in the cycle the block leaves EMIT.
REQ-028 flush asserted outside RUN SHALL be ignored.
REQ-029 Deasserting enable SHALL only stop new reads; an in-flight byte SHALL still be captured.
REQ-030 rd_en SHALL never be asserted while rd_empty=1.

Reset
REQ-031 While rst_n=0: state=RUN, pack_cnt=0, inflight=0, rd_en=0, m_valid=0, m_data=0, m_keep=0, m_last=0, flush_done=0.
REQ-032 Reset mid-word SHALL discard packed and in-flight bytes; no word or flush_done is emitted afterwards for them.

Structure
REQ-033 Package sync_fifo_rd_pkg SHALL hold OUT_BYTES, BYTE_W, the state enum (RUN, DRAIN, EMIT) and the keep-mask width.
REQ-034 The lane register, pack_cnt and keep generation SHALL be one sub-module, byte_pack_4to32; the FSM, read issue and output slot SHALL stay in the top module.

Verification
REQ-035 Bytes 0x11,0x22,0x33,0x44 in FIFO, m_ready=1 -> rd_en cycles 0-3, m_valid cycle 5, m_data=0x44332211, m_keep=F, m_last=0.
REQ-036 8 bytes 0x01..0x08, m_ready=0 until cycle 12 -> second pack held, reads stall; words 0x04030201 then 0x08070605, each exactly once.
REQ-037 3 bytes 0xAA,0xBB,0xCC then flush -> m_data=0x00CCBBAA, m_keep=0111, m_last=1, flush_done one cycle later with the EMIT exit.
REQ-038 flush with pack_cnt=0, FIFO empty -> no m_valid, flush_done pulses within 2 cycles.
REQ-039 rst_n low for 1 cycle after 2 bytes packed -> all outputs at reset values; next 4 bytes form a clean word.
REQ-040 Random rd_empty and m_ready over 10000 bytes -> output byte stream equals input order; rd_en never high while rd_empty=1.
